dma_controller: RTL and testbench
=================================

Name: dma_controller

Overview:
- Memory-to-memory block-copy engine that shares the 16-bit system bus and memory module with the instruction controller.
- Requests the bus with a HOLD/HLDA handshake. While granted, it drives the bus, the memory MAR write and the memory write strobes itself, moving one byte per 4-cycle bus sequence.
- It is configured through a small register-write port (src, dst, count, start) and reports busy and done.

Parameters:
- BURST, 1, 1 = keep hold for the whole block; 0 = cycle-steal (release hold for at least one cycle after every byte).
- ADDR_W, 16, address and count width; must equal bus width.

Ports:
- clk_out  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_write_en  input  1  configuration register write strobe.
- cfg_sel  input  2  register select: 0=src, 1=dst, 2=count, 3=start (data ignored).
- cfg_data  input  16  configuration write data.
- hlda  input  1  bus grant from the controller; only sampled while hold is high.
- mem_data_in  input  8  memory read data (memory out port).
- hold  output  1  bus request, registered.
- dma_out_en  output  1  DMA drives bus_out onto the system bus.
- bus_out  output  16  value DMA places on the bus.
- mar_write_en  output  1  memory MAR load strobe.
- mem_write_en  output  1  memory write strobe; data is bus[7:0].
- busy  output  1  transfer in progress (start accepted, done not yet issued).
- done  output  1  one-cycle pulse on transfer completion.

Behaviour:
- Reset (async): state=IDLE; src, dst, count and data_reg are 0; every output is 0.
- Config writes take effect on the clock edge. Writes while busy=1 are ignored, including start.
- Start with count=0: no hold. done pulses on the next cycle and busy stays 0.
- Start with count≠0: the next state is REQ. busy=1 and hold=1 from the cycle after the start write.
- States: IDLE, REQ, SRC_ADDR, READ, DST_ADDR, WRITE, GAP.
- REQ: hold=1; all bus-side outputs are 0. On hlda=1, go to SRC_ADDR.
- SRC_ADDR: dma_out_en=1, bus_out=src, mar_write_en=1.
- READ: dma_out_en=0; data_reg<=mem_data_in at the end of the cycle.
- DST_ADDR: dma_out_en=1, bus_out=dst, mar_write_en=1.
- WRITE: dma_out_en=1, bus_out={8'h00,data_reg}, mem_write_en=1. At the end of the cycle: src<=src+1, dst<=dst+1, count<=count-1 (all modulo 2^16, so 16'hFFFF wraps to 16'h0000).
- After WRITE when the new count=0: hold falls and done=1 for one cycle; go to IDLE with busy=0 in that same cycle.
- After WRITE when count≠0 and BURST=1: go to SRC_ADDR.
- After WRITE when count≠0 and BURST=0: go to GAP (hold=0 for one cycle), then REQ.
- Bus-side outputs (dma_out_en, bus_out, mar_write_en, mem_write_en) are Moore decodes of the state. All of them are 0 outside SRC_ADDR/DST_ADDR/WRITE. bus_out=0 whenever dma_out_en=0.
- hold=1 in REQ, SRC_ADDR, READ, DST_ADDR and WRITE, and 0 otherwise.
- Throughput with BURST=1: 4 cycles per byte after the grant.
- hlda falls in SRC_ADDR, READ or DST_ADDR: abort the current byte with no increments and return to REQ (hold stays 1). The byte restarts from SRC_ADDR when hlda returns.
- hlda falls in WRITE: the write completes (the strobe is already issued), then REQ or completion as normal.
- rst mid-transfer: immediate return to IDLE, hold=0 and all strobes 0. The partial copy is not resumed.
- Overlapping src/dst ranges: the copy is performed in ascending address order with no correction.

Test Plan:
1. Reset → all outputs 0. Write src=16'h0010, dst=16'h0080, count=3, then start.
   - Required: hold=1 on the next cycle; hlda tied 1.
   - Required bus sequence: 16'h0010, (read), 16'h0080, data.
   - Required result: mem[0x80..0x82]=mem[0x10..0x12]; done pulses once after 12 granted cycles; busy falls with done.
2. Start with count=0 → hold never asserts; done=1 for exactly one cycle; busy stays 0; no strobes.
3. BURST=0 with count=2 → hold drops for exactly one cycle (GAP) between bytes; both bytes are copied correctly.
4. Hold hlda=0 for 5 cycles after the request → FSM stays in REQ with dma_out_en=0. Raise hlda → the transfer starts on the next cycle.
5. Deassert hlda during READ of byte 1 → src, dst and count are unchanged; after re-grant, byte 1 is re-copied and the final memory contents are correct.
6. src=16'hFFFF, count=2 → the second read address is 16'h0000. Assert rst in a later run mid-transfer → hold, busy and strobes are 0 immediately; a config write of start=1 while busy is ignored.

Source files
------------

// File: rtl/dma_controller.sv
// Memory-to-memory block-copy engine sharing the system bus via a HOLD/HLDA handshake.
// Each byte moves in four bus cycles: source address, read, destination address, write.
module dma_controller #(
    parameter int unsigned BURST  = 1,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_out,
    input  logic              rst,
    input  logic              cfg_write_en,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              hlda,
    input  logic [7:0]        mem_data_in,
    output logic              hold,
    output logic              dma_out_en,
    output logic [ADDR_W-1:0] bus_out,
    output logic              mar_write_en,
    output logic              mem_write_en,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_SRC_ADDR = 3'd2;
    localparam logic [2:0] S_READ     = 3'd3;
    localparam logic [2:0] S_DST_ADDR = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;
    localparam logic [2:0] S_GAP      = 3'd6;

    localparam logic [1:0] SEL_SRC   = 2'd0;
    localparam logic [1:0] SEL_DST   = 2'd1;
    localparam logic [1:0] SEL_COUNT = 2'd2;
    localparam logic [1:0] SEL_START = 2'd3;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_count;
    logic [7:0]        r_data;
    logic              r_hold;
    logic              r_done;

    logic              w_cfg_en;
    logic              w_start;
    logic [ADDR_W-1:0] w_count_dec;
    logic              w_last;
    logic              w_hold_next;
    logic              w_done_next;
    logic [ADDR_W-1:0] w_bus_data;

    // Config writes are only honoured while idle; this also blocks a start while busy.
    assign w_cfg_en    = cfg_write_en && (r_state == S_IDLE);
    assign w_start     = w_cfg_en && (cfg_sel == SEL_START);
    assign w_count_dec = r_count - ADDR_W'(1);
    assign w_last      = (w_count_dec == '0);
    assign w_bus_data  = {{(ADDR_W-8){1'b0}}, r_data};

    // Next-state selection for the transfer sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start && (r_count != '0)) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (hlda) begin
                    w_next = S_SRC_ADDR;
                end
            end
            // Losing the grant before the write strobe abandons the byte; it restarts intact.
            S_SRC_ADDR: w_next = hlda ? S_READ : S_REQ;
            S_READ:     w_next = hlda ? S_DST_ADDR : S_REQ;
            S_DST_ADDR: w_next = hlda ? S_WRITE : S_REQ;
            S_WRITE: begin
                if (w_last) begin
                    w_next = S_IDLE;
                end else if (BURST != 0) begin
                    w_next = S_SRC_ADDR;
                end else begin
                    w_next = S_GAP;
                end
            end
            S_GAP:   w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    // Hold is registered from the next state so it tracks the state without decode glitches.
    always_comb begin
        w_hold_next = (w_next == S_REQ) || (w_next == S_SRC_ADDR) || (w_next == S_READ) ||
                      (w_next == S_DST_ADDR) || (w_next == S_WRITE);
        w_done_next = (w_start && (r_count == '0)) || ((r_state == S_WRITE) && w_last);
    end

    // Sequencer state, bus request and completion pulse.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= w_hold_next;
            r_done  <= w_done_next;
        end
    end

    // Address and count registers: loaded by config, advanced after each completed write.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
        end else if (r_state == S_WRITE) begin
            r_src   <= r_src + ADDR_W'(1);
            r_dst   <= r_dst + ADDR_W'(1);
            r_count <= w_count_dec;
        end else if (w_cfg_en) begin
            case (cfg_sel)
                SEL_SRC:   r_src   <= cfg_data;
                SEL_DST:   r_dst   <= cfg_data;
                SEL_COUNT: r_count <= cfg_data;
                default:   ;
            endcase
        end
    end

    // Byte buffer captured at the end of the read cycle.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_data <= 8'h00;
        end else if (r_state == S_READ) begin
            r_data <= mem_data_in;
        end
    end

    // Moore decode of the bus-side outputs; the bus is zero whenever it is not driven.
    always_comb begin
        dma_out_en   = 1'b0;
        bus_out      = '0;
        mar_write_en = 1'b0;
        mem_write_en = 1'b0;
        case (r_state)
            S_SRC_ADDR: begin
                dma_out_en   = 1'b1;
                bus_out      = r_src;
                mar_write_en = 1'b1;
            end
            S_DST_ADDR: begin
                dma_out_en   = 1'b1;
                bus_out      = r_dst;
                mar_write_en = 1'b1;
            end
            S_WRITE: begin
                dma_out_en   = 1'b1;
                bus_out      = w_bus_data;
                mem_write_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign hold = r_hold;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: a burst and a cycle-steal instance, each with its own memory.
// Expected bus events come from a byte-copy reference model and are checked by a monitor.
module tb_dma_controller;

    localparam int unsigned BURST0 = 1;
    localparam int unsigned BURST1 = 0;

    typedef struct packed {
        logic [1:0]  kind;  // 0 address strobe, 1 write strobe, 2 done, 3 cycle-steal gap
        logic [15:0] val;
    } ev_t;

    logic        clk_out = 1'b0;
    logic        rst     = 1'b1;
    logic        cfg_we   [2];
    logic [1:0]  cfg_sel  [2];
    logic [15:0] cfg_data [2];
    logic        hlda     [2];
    logic [7:0]  mdin     [2];
    logic        hold     [2];
    logic        oen      [2];
    logic [15:0] bus      [2];
    logic        marwe    [2];
    logic        memwe    [2];
    logic        busy     [2];
    logic        done     [2];

    logic [7:0]  mem     [2][65536];
    logic [7:0]  ref_mem [2][65536];
    logic [15:0] mar     [2];

    ev_t q0[$];
    ev_t q1[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk_out = ~clk_out;

    dma_controller #(.BURST(BURST0), .ADDR_W(16)) u_dma_burst (
        .clk_out(clk_out), .rst(rst), .cfg_write_en(cfg_we[0]), .cfg_sel(cfg_sel[0]),
        .cfg_data(cfg_data[0]), .hlda(hlda[0]), .mem_data_in(mdin[0]), .hold(hold[0]),
        .dma_out_en(oen[0]), .bus_out(bus[0]), .mar_write_en(marwe[0]),
        .mem_write_en(memwe[0]), .busy(busy[0]), .done(done[0])
    );

    dma_controller #(.BURST(BURST1), .ADDR_W(16)) u_dma_steal (
        .clk_out(clk_out), .rst(rst), .cfg_write_en(cfg_we[1]), .cfg_sel(cfg_sel[1]),
        .cfg_data(cfg_data[1]), .hlda(hlda[1]), .mem_data_in(mdin[1]), .hold(hold[1]),
        .dma_out_en(oen[1]), .bus_out(bus[1]), .mar_write_en(marwe[1]),
        .mem_write_en(memwe[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic logic [7:0] init_byte(int k, int a);
        return 8'((a * 197) ^ (a >> 7) ^ (k * 91) ^ 8'h5a);
    endfunction

    // Memory module: MAR load on the address strobe, byte write on the write strobe.
    initial begin
        for (int k = 0; k < 2; k++) begin
            mar[k] <= 16'h0000;
            for (int a = 0; a < 65536; a++) mem[k][a] <= init_byte(k, a);
        end
        forever begin
            @(posedge clk_out);
            for (int k = 0; k < 2; k++) begin
                if (marwe[k]) mar[k] <= bus[k];
                if (memwe[k]) mem[k][mar[k]] <= bus[k][7:0];
            end
        end
    end

    assign mdin[0] = mem[0][mar[0]];
    assign mdin[1] = mem[1][mar[1]];

    function automatic void push_ev(int k, logic [1:0] kind, logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t pop_ev(int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void clear_q(int k);
        if (k == 0) q0.delete();
        else q1.delete();
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h", name, k, act, exp);
        end
    endtask

    // Reference model: ascending byte-by-byte copy, 16-bit address wrap, optional restart
    // of the first byte after a grant loss during its read.
    task automatic expect_xfer(input int k, input logic [15:0] s, input logic [15:0] d,
                               input logic [15:0] c, input bit abort_first);
        logic [15:0] sa;
        logic [15:0] da;
        logic [7:0]  b;
        bit          steal;
        steal = ((k == 0) ? BURST0 : BURST1) == 0;
        for (int i = 0; i < int'(c); i++) begin
            sa = 16'(s + i);
            da = 16'(d + i);
            if (i == 0 && abort_first) push_ev(k, 2'd0, sa);
            push_ev(k, 2'd0, sa);
            push_ev(k, 2'd0, da);
            b = ref_mem[k][sa];
            ref_mem[k][da] = b;
            push_ev(k, 2'd1, {8'h00, b});
            if (steal && i != int'(c) - 1) push_ev(k, 2'd3, 16'h0000);
        end
        push_ev(k, 2'd2, 16'h0000);
    endtask

    // Monitor: invariants every cycle, then one observed event popped against the model.
    task automatic mon(input int k);
        ev_t obs;
        ev_t e;
        bit  has;
        check("oen_decode", k, oen[k], marwe[k] | memwe[k]);
        if (!oen[k]) check("idle_bus", k, bus[k], 0);
        check("hold_without_busy", k, hold[k] & ~busy[k], 0);
        has = 1'b1;
        if (marwe[k]) begin
            obs.kind = 2'd0; obs.val = bus[k];
        end else if (memwe[k]) begin
            obs.kind = 2'd1; obs.val = bus[k];
        end else if (done[k]) begin
            obs.kind = 2'd2; obs.val = {14'h0, busy[k], hold[k]};
        end else if (busy[k] && !hold[k]) begin
            obs.kind = 2'd3; obs.val = 16'h0000;
        end else begin
            has = 1'b0;
        end
        if (has) begin
            if (qsize(k) == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event inst=%0d got=%h want=none", k, obs);
            end else begin
                e = pop_ev(k);
                check("bus_event", k, 32'(obs), 32'(e));
            end
        end
    endtask

    always @(negedge clk_out) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    task automatic cfg_wr(input int k, input logic [1:0] sel, input logic [15:0] d);
        cfg_we[k]   = 1'b1;
        cfg_sel[k]  = sel;
        cfg_data[k] = d;
        @(posedge clk_out);
        #1;
        cfg_we[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, output int n);
        n = 0;
        while (qsize(k) != 0 && n < 400) begin
            @(posedge clk_out);
            #1;
            n++;
        end
        if (qsize(k) != 0) begin
            check("timeout", k, qsize(k), 0);
            clear_q(k);
        end
    endtask

    task automatic check_mem(input int k, input logic [15:0] d, input logic [15:0] c);
        logic [15:0] a;
        for (int i = 0; i < int'(c); i++) begin
            a = 16'(d + i);
            check("mem_copy", k, mem[k][a], ref_mem[k][a]);
        end
    endtask

    task automatic run(input int k, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] c, input int stall, input bit abort_first,
                       input bit poke, input int want_lat);
        int n;
        hlda[k] = (stall == 0);
        cfg_wr(k, 2'd0, s);
        cfg_wr(k, 2'd1, d);
        cfg_wr(k, 2'd2, c);
        expect_xfer(k, s, d, c, abort_first);
        cfg_wr(k, 2'd3, 16'h0000);
        if (c == 0) begin
            check("zero_hold_busy", k, {hold[k], busy[k]}, 2'b00);
            check("zero_done", k, done[k], 1);
        end else begin
            check("start_hold_busy", k, {hold[k], busy[k]}, 2'b11);
        end
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                check("stall_in_req", k, {hold[k], oen[k]}, 2'b10);
                @(posedge clk_out);
                #1;
            end
            hlda[k] = 1'b1;
            @(posedge clk_out);
            #1;
            check("grant_src", k, {marwe[k], bus[k]}, {1'b1, s});
        end
        if (abort_first) begin
            repeat (2) begin
                @(posedge clk_out);
                #1;
            end
            hlda[k] = 1'b0;
            @(posedge clk_out);
            #1;
            check("abort_to_req", k, {hold[k], busy[k], oen[k]}, 3'b110);
            hlda[k] = 1'b1;
        end
        if (poke) begin
            @(posedge clk_out);
            #1;
            cfg_wr(k, 2'd0, 16'h5555);
            cfg_wr(k, 2'd3, 16'h0000);
        end
        wait_idle(k, n);
        if (want_lat > 0) check("done_latency", k, n, want_lat);
        check_mem(k, d, c);
        if (poke) begin
            repeat (20) @(posedge clk_out);
            #1;
            check("poke_idle", k, busy[k], 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog inst=0 got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] c;
        for (int i = 0; i < 2; i++) begin
            cfg_we[i] = 1'b0; cfg_sel[i] = 2'd0; cfg_data[i] = 16'h0; hlda[i] = 1'b1;
            for (int a = 0; a < 65536; a++) ref_mem[i][a] = init_byte(i, a);
        end
        repeat (2) @(posedge clk_out);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_outputs", i, {hold[i], oen[i], marwe[i], memwe[i], busy[i], done[i]}, 0);
            check("reset_bus", i, bus[i], 0);
        end
        rst = 1'b0;
        @(posedge clk_out);
        #1;

        run(0, 16'h0010, 16'h0080, 16'd3, 0, 1'b0, 1'b0, 14);  // basic burst copy
        run(0, 16'h0100, 16'h0200, 16'd0, 0, 1'b0, 1'b0, 0);   // zero count
        run(1, 16'h0300, 16'h0400, 16'd2, 0, 1'b0, 1'b0, 0);   // cycle-steal gap
        run(0, 16'h0500, 16'h0600, 16'd2, 5, 1'b0, 1'b0, 0);   // delayed grant
        run(0, 16'h0700, 16'h0800, 16'd3, 0, 1'b1, 1'b0, 0);   // grant lost in read
        run(0, 16'hFFFF, 16'h4000, 16'd2, 0, 1'b0, 1'b0, 0);   // source wrap
        run(0, 16'h0A00, 16'h0B00, 16'd3, 0, 1'b0, 1'b1, 0);   // writes while busy

        for (int t = 0; t < 16; t++) begin
            k = int'($urandom_range(0, 1));
            s = 16'($urandom);
            d = 16'($urandom);
            c = 16'($urandom_range(0, 6));
            run(k, s, d, c, 0, 1'b0, 1'b0, 0);
        end

        // Reset in the middle of a transfer.
        hlda[0] = 1'b1;
        cfg_wr(0, 2'd0, 16'h7000);
        cfg_wr(0, 2'd1, 16'h9000);
        cfg_wr(0, 2'd2, 16'd6);
        expect_xfer(0, 16'h7000, 16'h9000, 16'd6, 1'b0);
        cfg_wr(0, 2'd3, 16'h0000);
        repeat (6) @(posedge clk_out);
        #2;
        rst = 1'b1;
        #1;
        check("rst_outputs", 0, {hold[0], oen[0], marwe[0], memwe[0], busy[0], done[0]}, 0);
        check("rst_bus", 0, bus[0], 0);
        clear_q(0);
        @(posedge clk_out);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk_out);
        #1;
        check("rst_stays_idle", 0, {hold[0], busy[0]}, 0);
        run(0, 16'h2000, 16'h3000, 16'd3, 0, 1'b0, 1'b0, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
